fifo_wr_ptr_full: RTL
=====================

FIFO_WR_PTR_FULL -- requirements
Module: fifo_wr_ptr_full

Interface
REQ-001 The block SHALL have one clock, i_WR_clk; reset is asynchronous and active-low, i_WR_rst_n.
REQ-002 Parameter DEPTH, default 4, SHALL set the address width; storage is 2**DEPTH words, pointers are DEPTH+1 bits, and legal values are DEPTH >= 2.
REQ-003 Parameter AF_MARGIN, default 2, SHALL set the almost-full threshold, in free words; legal values are 1 to 2**DEPTH-1.
REQ-004 Port i_WR_clk  input  1  write-domain clock.
REQ-005 Port i_WR_rst_n  input  1  asynchronous active-low reset.
REQ-006 Port i_WR_En  input  1  write request from producer.
REQ-007 Port i_RD_Ptr_Gray  input  DEPTH+1  Gray-coded read pointer from read domain, asynchronous to i_WR_clk.
REQ-008 Port i_Ovf_Clr  input  1  synchronous clear of the overflow flag.
REQ-009 Port o_WR_Addr  output  DEPTH  binary write address to the FIFO storage array.
REQ-010 Port o_WR_Ptr_Gray  output  DEPTH+1  registered Gray write pointer for read-domain synchronisation.
REQ-011 Port o_Full  output  1  FIFO full; also drives the storage array write-inhibit input.
REQ-012 Port o_Almost_Full  output  1  free words <= AF_MARGIN.
REQ-013 Port o_WR_Count  output  DEPTH+1  write-side fill level, 0 to 2**DEPTH.
REQ-014 Port o_Overflow  output  1  sticky flag: write attempted while full.

Function
REQ-015 i_RD_Ptr_Gray SHALL pass through a two-flop synchronizer (rq1 then rq2) clocked by i_WR_clk, with no logic between the flops.
REQ-016 A write SHALL be accepted (wr_acc) when i_WR_En=1 and o_Full=0 at the clock edge.
REQ-017 The binary pointer wbin SHALL update as wbin_next = wbin + wr_acc, modulo 2**(DEPTH+1).
REQ-018 The Gray pointer SHALL update as gray_next = (wbin_next >> 1) XOR wbin_next, and o_WR_Ptr_Gray SHALL be registered directly from gray_next with no output logic after the register.
REQ-019 o_WR_Addr SHALL equal wbin[DEPTH-1:0] of the registered pointer, with zero latency from the pointer register.
REQ-020 full_next SHALL be 1 iff gray_next equals rq2 with its two MSBs inverted and the remaining bits unchanged, and o_Full SHALL be registered from full_next.
REQ-021 The synchronized read pointer SHALL be converted Gray-to-binary (rbin), and o_WR_Count SHALL be registered from (wbin_next - rbin) modulo 2**(DEPTH+1).
REQ-022 o_Almost_Full SHALL be registered from (wbin_next - rbin) >= 2**DEPTH - AF_MARGIN.
REQ-023 o_Overflow SHALL set on any edge where i_WR_En=1 and o_Full=1, and SHALL clear on an edge where i_Ovf_Clr=1; when set and clear occur on the same edge, set SHALL win.
REQ-024 A write attempted while full SHALL leave wbin, o_WR_Ptr_Gray and o_WR_Addr unchanged.
REQ-025 o_Full SHALL assert on the same edge that accepts the write filling the last free word, so no extra write slips through.
REQ-026 A change on i_RD_Ptr_Gray SHALL be reflected in o_Full, o_Almost_Full and o_WR_Count on the third i_WR_clk edge after the change (pessimistic: full may persist, it is never early).
REQ-027 o_WR_Ptr_Gray SHALL change at most one bit per clock, including at wrap from 2**(DEPTH+1)-1 to 0.

Reset
REQ-028 While i_WR_rst_n=0, all outputs SHALL be forced to 0 without waiting for a clock edge: rq1, rq2, wbin, o_WR_Ptr_Gray, o_WR_Addr, o_Full, o_Almost_Full, o_WR_Count and o_Overflow.
REQ-029 Reset asserted mid-operation SHALL discard all pointer state, and the first write after release SHALL go to address 0.
REQ-030 The block SHALL leave reset on the first i_WR_clk edge after i_WR_rst_n rises, with no extra idle cycles.

Verification (DEPTH=4, AF_MARGIN=2)
REQ-031 Reset check: assert i_WR_rst_n=0 between clock edges after 5 writes -> all outputs 0 immediately, and the next write uses o_WR_Addr=0.
REQ-032 Fill check: i_RD_Ptr_Gray=0, i_WR_En=1 held for 16 cycles -> o_WR_Addr steps 0..15 then 0; o_Almost_Full=1 once o_WR_Count=14; o_Full=1 with o_WR_Count=16 after the 16th edge.
REQ-033 Overflow check: with o_Full=1, pulse i_WR_En -> pointer unchanged and o_Overflow=1; i_Ovf_Clr alone -> 0; i_Ovf_Clr together with i_WR_En while full -> o_Overflow stays 1.
REQ-034 Release check: with o_Full=1, drive i_RD_Ptr_Gray=5'b00001 -> o_Full=0 and o_WR_Count=15 on the third edge, not earlier.
REQ-035 Wrap check: 32 writes with the read pointer trailing by 4 -> o_WR_Ptr_Gray returns to 0, each step differs by exactly one bit, and o_Full is never asserted.
REQ-036 Random check: random i_WR_En and a monotonically advancing i_RD_Ptr_Gray against a reference count model -> o_WR_Count never exceeds 16, and no write is accepted while o_Full=1.

Source files
------------

// File: rtl/fifo_wr_ptr_full.sv
// Write-side pointer, full/almost-full and fill-level logic for an asynchronous FIFO.
// The read pointer arrives in Gray code and is resynchronised here through two flops.
module fifo_wr_ptr_full #(
   parameter int DEPTH     = 4,
   parameter int AF_MARGIN = 2
) (
   input  logic             i_WR_clk,
   input  logic             i_WR_rst_n,
   input  logic             i_WR_En,
   input  logic [DEPTH:0]   i_RD_Ptr_Gray,
   input  logic             i_Ovf_Clr,
   output logic [DEPTH-1:0] o_WR_Addr,
   output logic [DEPTH:0]   o_WR_Ptr_Gray,
   output logic             o_Full,
   output logic             o_Almost_Full,
   output logic [DEPTH:0]   o_WR_Count,
   output logic             o_Overflow
);

   localparam int            PW       = DEPTH + 1;
   localparam logic [PW-1:0] AF_LEVEL = PW'((2 ** DEPTH) - AF_MARGIN);

   function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
      logic [PW-1:0] b;
      b[PW-1] = g[PW-1];
      for (int i = PW - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   logic [PW-1:0] r_rq1;
   logic [PW-1:0] r_rq2;
   logic [PW-1:0] r_wbin;

   logic          w_wr_acc;
   logic [PW-1:0] w_wbin_next;
   logic [PW-1:0] w_gray_next;
   logic [PW-1:0] w_rbin;
   logic [PW-1:0] w_full_cmp;
   logic [PW-1:0] w_count_next;
   logic          w_full_next;
   logic          w_af_next;

   // Stage boundary: read pointer crosses into the write clock domain.
   always_ff @(posedge i_WR_clk or negedge i_WR_rst_n) begin
      if (!i_WR_rst_n) begin
         r_rq1 <= '0;
         r_rq2 <= '0;
      end else begin
         r_rq1 <= i_RD_Ptr_Gray;
         r_rq2 <= r_rq1;
      end
   end

   assign w_wr_acc     = i_WR_En & ~o_Full;
   assign w_wbin_next  = r_wbin + PW'(w_wr_acc);
   assign w_gray_next  = (w_wbin_next >> 1) ^ w_wbin_next;
   assign w_rbin       = gray2bin(r_rq2);
   // Full when the write pointer has lapped the read pointer by exactly one turn.
   assign w_full_cmp   = {~r_rq2[PW-1:PW-2], r_rq2[PW-3:0]};
   assign w_full_next  = (w_gray_next == w_full_cmp);
   assign w_count_next = w_wbin_next - w_rbin;
   assign w_af_next    = (w_count_next >= AF_LEVEL);

   // Stage boundary: pointer and status registers.
   always_ff @(posedge i_WR_clk or negedge i_WR_rst_n) begin
      if (!i_WR_rst_n) begin
         r_wbin        <= '0;
         o_WR_Ptr_Gray <= '0;
         o_Full        <= 1'b0;
         o_Almost_Full <= 1'b0;
         o_WR_Count    <= '0;
         o_Overflow    <= 1'b0;
      end else begin
         r_wbin        <= w_wbin_next;
         o_WR_Ptr_Gray <= w_gray_next;
         o_Full        <= w_full_next;
         o_Almost_Full <= w_af_next;
         o_WR_Count    <= w_count_next;
         if (i_WR_En && o_Full) begin
            o_Overflow <= 1'b1;
         end else if (i_Ovf_Clr) begin
            o_Overflow <= 1'b0;
         end
      end
   end

   assign o_WR_Addr = r_wbin[DEPTH-1:0];

endmodule
